// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM-stage load/store port: one access at a time,
// WAIT_CYCLES wait states, big-endian byte lanes, full-word read data.
module data_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              commit;
  logic              commit_wr;
  logic [31:0]       wmerge;

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];

  // Address bits outside the word index are intentionally don't-care.
  logic unused_addr;
  assign unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  // In IDLE the _d request fields equal the live inputs, elsewhere the latched
  // copy, so the commit path below serves both the zero-wait and waited cases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_ce_i) begin
          idx_d   = mem_addr_i[ADDR_W+1:2];
          we_d    = mem_we_i;
          sel_d   = mem_sel_i;
          wdata_d = mem_data_i;
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
            commit  = 1'b1;
          end else begin
            state_d = S_BUSY;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wmerge = mem_q[idx_d];
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel_d[i]) wmerge[8*i +: 8] = wdata_d[8*i +: 8];
    end
  end

  assign commit_wr = commit & we_d & rst;
  assign rdata_d   = (commit && !we_d) ? mem_q[idx_d] : rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never reset; a write aborted by reset simply never commits.
  always_ff @(posedge clk) begin
    if (commit_wr) mem_q[idx_d] <= wmerge;
  end

  assign mem_data_o  = rdata_q;
  assign mem_ready_o = (state_q == S_DONE);
  assign stall_req_o = rst & (((state_q == S_IDLE) & mem_ce_i) | (state_q == S_BUSY));

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance A has one wait state, instance B has none.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        ce_a, we_a, ce_b, we_b;
  logic [31:0] addr_a, wd_a, addr_b, wd_b;
  logic [3:0]  sel_a, sel_b;
  logic [31:0] rd_a, rd_b;
  logic        rdy_a, stl_a, rdy_b, stl_b;

  int checks;
  int failures;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst),
    .mem_ce_i(ce_a), .mem_we_i(we_a), .mem_addr_i(addr_a), .mem_sel_i(sel_a),
    .mem_data_i(wd_a), .mem_data_o(rd_a), .mem_ready_o(rdy_a), .stall_req_o(stl_a)
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst),
    .mem_ce_i(ce_b), .mem_we_i(we_b), .mem_addr_i(addr_b), .mem_sel_i(sel_b),
    .mem_data_i(wd_b), .mem_data_o(rd_b), .mem_ready_o(rdy_b), .stall_req_o(stl_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic        exp_stall;
    logic        exp_ready;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ce, input logic we, input logic [31:0] addr,
                              input logic [3:0] sel, input logic [31:0] data,
                              input logic st, input logic rdy, input logic [31:0] rd);
    vec_t v;
    v.ce = ce; v.we = we; v.addr = addr; v.sel = sel; v.data = data;
    v.exp_stall = st; v.exp_ready = rdy; v.exp_rdata = rd;
    return v;
  endfunction

  // Full access with ce held high (pipeline stalled) on instance A (b=0) or B (b=1).
  task automatic access(input bit b, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] data,
                        input logic [31:0] exp_rd, input string nm);
    int n;
    n = b ? 2 : 3;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (b) begin
        ce_b = 1'b1; we_b = we; addr_b = addr; sel_b = sel; wd_b = data;
      end else begin
        ce_a = 1'b1; we_a = we; addr_a = addr; sel_a = sel; wd_a = data;
      end
      #1;
      chk({nm, "_stall"}, {31'd0, b ? stl_b : stl_a}, {31'd0, (i < n - 1)});
      chk({nm, "_ready"}, {31'd0, b ? rdy_b : rdy_a}, {31'd0, (i == n - 1)});
      if (i == n - 1) chk({nm, "_rdata"}, b ? rd_b : rd_a, exp_rd);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ce_a = 1'b0; ce_b = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    ce_a = 1'b1; we_a = 1'b0; addr_a = '0; sel_a = '0; wd_a = '0;
    ce_b = 1'b1; we_b = 1'b0; addr_b = '0; sel_b = '0; wd_b = '0;

    // reset state, with ce high: stall must still be forced low
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata_a", rd_a, 32'h0);
    chk("rst_ready_a", {31'd0, rdy_a}, 32'd0);
    chk("rst_stall_a", {31'd0, stl_a}, 32'd0);
    chk("rst_stall_b", {31'd0, stl_b}, 32'd0);
    ce_a = 1'b0; ce_b = 1'b0;
    #2 rst = 1'b1;

    // write/read, byte-lane write, sel=0000 write, on the one-wait instance
    vecs.push_back(mk(1, 1, 32'h10, 4'b1111, 32'h12345678, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h10, 4'b1111, 32'h12345678, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h10, 4'b1111, 32'h12345678, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h10, 4'b0000, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h10, 4'b0000, 32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h10, 4'b0000, 32'h0,        0, 1, 32'h12345678));
    vecs.push_back(mk(1, 1, 32'h11, 4'b0100, 32'hAAAAAAAA, 1, 0, 32'h12345678));
    vecs.push_back(mk(1, 1, 32'h11, 4'b0100, 32'hAAAAAAAA, 1, 0, 32'h12345678));
    vecs.push_back(mk(1, 1, 32'h11, 4'b0100, 32'hAAAAAAAA, 0, 1, 32'h12345678));
    vecs.push_back(mk(1, 0, 32'h10, 4'b1111, 32'h0,        1, 0, 32'h12345678));
    vecs.push_back(mk(1, 0, 32'h10, 4'b1111, 32'h0,        1, 0, 32'h12345678));
    vecs.push_back(mk(1, 0, 32'h10, 4'b1111, 32'h0,        0, 1, 32'h12AA5678));
    vecs.push_back(mk(1, 1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1, 0, 32'h12AA5678));
    vecs.push_back(mk(1, 1, 32'h10, 4'b0000, 32'hFFFFFFFF, 1, 0, 32'h12AA5678));
    vecs.push_back(mk(1, 1, 32'h10, 4'b0000, 32'hFFFFFFFF, 0, 1, 32'h12AA5678));
    vecs.push_back(mk(1, 0, 32'h13, 4'b0001, 32'h0,        1, 0, 32'h12AA5678));
    vecs.push_back(mk(1, 0, 32'h13, 4'b0001, 32'h0,        1, 0, 32'h12AA5678));
    vecs.push_back(mk(1, 0, 32'h13, 4'b0001, 32'h0,        0, 1, 32'h12AA5678));
    vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 32'h0,        0, 0, 32'h12AA5678));

    foreach (vecs[k]) begin
      @(negedge clk);
      ce_a = vecs[k].ce; we_a = vecs[k].we; addr_a = vecs[k].addr;
      sel_a = vecs[k].sel; wd_a = vecs[k].data;
      #1;
      chk($sformatf("vec%0d_stall", k), {31'd0, stl_a}, {31'd0, vecs[k].exp_stall});
      chk($sformatf("vec%0d_ready", k), {31'd0, rdy_a}, {31'd0, vecs[k].exp_ready});
      chk($sformatf("vec%0d_rdata", k), rd_a, vecs[k].exp_rdata);
    end

    // zero-wait instance: preload, back-to-back reads, write in between
    access(1'b1, 1'b1, 32'h40, 4'hF, 32'h11111111, 32'h0, "b_w40");
    access(1'b1, 1'b1, 32'h44, 4'hF, 32'h22222222, 32'h0, "b_w44");
    access(1'b1, 1'b1, 32'h48, 4'hF, 32'h33333333, 32'h0, "b_w48");
    access(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h11111111, "b_r40");
    access(1'b1, 1'b0, 32'h44, 4'hF, 32'h0, 32'h22222222, "b_r44");
    access(1'b1, 1'b1, 32'h40, 4'hF, 32'h99999999, 32'h22222222, "b_wmid");
    access(1'b1, 1'b0, 32'h48, 4'hF, 32'h0, 32'h33333333, "b_r48");
    access(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h99999999, "b_r40b");
    idle_cycle();

    // asynchronous reset in the middle of a waited write
    access(1'b0, 1'b1, 32'h20, 4'hF, 32'h00000001, 32'h12AA5678, "a_w20");
    @(negedge clk);
    ce_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; sel_a = 4'hF; wd_a = 32'hDEADBEEF;
    @(negedge clk);
    #1;
    chk("rstmid_busy_stall", {31'd0, stl_a}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rstmid_stall", {31'd0, stl_a}, 32'd0);
    chk("rstmid_ready", {31'd0, rdy_a}, 32'd0);
    chk("rstmid_rdata", rd_a, 32'h0);
    ce_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("post_rst_ready", {31'd0, rdy_a}, 32'd0);
    end
    access(1'b0, 1'b0, 32'h20, 4'hF, 32'h0, 32'h00000001, "a_r20");

    // request withdrawn in BUSY still completes
    @(negedge clk);
    ce_a = 1'b1; we_a = 1'b1; addr_a = 32'h24; sel_a = 4'hF; wd_a = 32'hCAFEF00D;
    #1;
    chk("wd_req_stall", {31'd0, stl_a}, 32'd1);
    @(negedge clk);
    ce_a = 1'b0; we_a = 1'b0; addr_a = 32'h0; wd_a = 32'h0;
    #1;
    chk("wd_busy_stall", {31'd0, stl_a}, 32'd1);
    chk("wd_busy_ready", {31'd0, rdy_a}, 32'd0);
    @(negedge clk);
    #1;
    chk("wd_done_ready", {31'd0, rdy_a}, 32'd1);
    chk("wd_done_stall", {31'd0, stl_a}, 32'd0);
    access(1'b0, 1'b0, 32'h24, 4'hF, 32'h0, 32'hCAFEF00D, "a_r24");

    // address aliasing above ADDR_W word bits
    access(1'b0, 1'b1, 32'h1000, 4'hF, 32'h55555555, 32'hCAFEF00D, "a_w1000");
    access(1'b0, 1'b0, 32'h0, 4'hF, 32'h0, 32'h55555555, "a_r0");
    idle_cycle();
    #1;
    chk("end_ready", {31'd0, rdy_a}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the far end of the MEM-stage load/store interface.
- Accepts ce/we/sel/addr/data requests and holds a word array with big-endian byte lanes.
- Inserts a configurable number of wait states, asking the pipeline controller to stall until the access completes.
- Returns the full read word; byte extraction and sign extension stay in the MEM stage.

Parameters:
ADDR_W, 10, word-address bits; array depth 2**ADDR_W 32-bit words
WAIT_CYCLES, 1, wait states per access (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
mem_ce_i  input  1  chip enable / request, 1 = access requested
mem_we_i  input  1  1 = write, 0 = read
mem_addr_i  input  32  byte address
mem_sel_i  input  4  byte-lane enables; sel[3]=bits31:24 (addr[1:0]=00) ... sel[0]=bits7:0 (addr[1:0]=11)
mem_data_i  input  32  write data, already lane-replicated by requester
mem_data_o  output  32  read data word
mem_ready_o  output  1  one-cycle completion pulse
stall_req_o  output  1  stall request to pipeline control

Behaviour:
- Storage: 2**ADDR_W x 32 array, not reset.
  - Word index = mem_addr_i[ADDR_W+1:2].
  - addr[1:0] ignored for indexing; higher address bits ignored (aliasing).
- Request capture:
  - In IDLE with mem_ce_i=1, on the clock edge latch addr index, we, sel and data into internal registers.
  - The request is then owned by the block. Later changes to mem_ce_i or the other inputs do not affect it.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when mem_ce_i=1 and WAIT_CYCLES>0; load wait counter with WAIT_CYCLES-1.
  - IDLE -> DONE when mem_ce_i=1 and WAIT_CYCLES=0.
  - BUSY: counter decrements each cycle; BUSY -> DONE on the edge where the counter is 0.
  - DONE -> IDLE unconditionally after one cycle. mem_ce_i still high in DONE belongs to the finished request and is ignored.
- Commit on the edge entering DONE:
  - Write: for each set sel bit, replace that byte lane of the addressed word with the matching lane of the latched data; other lanes unchanged.
  - Write with sel=0000: no array change; handshake still completes.
  - Read: mem_data_o <= array[index] (full word, sel ignored).
- Outputs:
  - mem_ready_o = 1 only in DONE, exactly one cycle per access, both reads and writes.
  - stall_req_o = (state==IDLE & mem_ce_i) | (state==BUSY). It is combinational on mem_ce_i in IDLE and 0 in DONE, so the pipeline advances at the end of DONE.
  - mem_data_o holds its last read value until the next read commits; writes never change it.
- Latency: access takes WAIT_CYCLES+2 cycles from request cycle through DONE; stall_req_o is high for WAIT_CYCLES+1 cycles.
- Request withdrawn (mem_ce_i -> 0 in BUSY, e.g. flush): access still completes normally, including the write commit and the ready pulse.
- Back-to-back: the next request is sampled only in IDLE, the cycle after DONE. No pipelining of accesses.
- Reset (rst=0, asynchronous, any state including mid-BUSY):
  - state=IDLE, counter=0, mem_data_o=0x00000000, mem_ready_o=0.
  - stall_req_o forced 0 while rst=0.
  - A pending write is dropped; array contents are preserved.

Test Plan:
1. WAIT_CYCLES=1: write we=1 sel=1111 addr=0x10 data=0x12345678, then read addr=0x10 -> stall_req_o high 2 cycles, ready pulse in cycle 3 of each access; read returns mem_data_o=0x12345678.
2. Byte write: we=1 sel=0100 addr=0x11 data=0xAAAAAAAA over word 0x12345678 -> subsequent read of 0x10 returns 0x12AA5678. Then sel=0000 write -> word unchanged, ready still pulses.
3. WAIT_CYCLES=0, three back-to-back reads held by stall:
   - Each access takes 2 cycles, stall high 1 cycle, one ready per access.
   - Each mem_data_o matches its address.
   - mem_data_o unchanged across an intervening write.
4. Assert rst=0 during BUSY of a write of 0xDEADBEEF to addr 0x20 (prior content 0x00000001):
   - Outputs go to 0 immediately, asynchronously.
   - After release a read of 0x20 returns 0x00000001, with no spurious ready.
5. Drop mem_ce_i to 0 in BUSY of a write of 0xCAFEF00D to addr 0x24 -> ready still pulses and a read returns 0xCAFEF00D. Then ADDR_W=10: write 0x55555555 to addr 0x1000 and read addr 0x0 -> 0x55555555 (aliasing).
